// File: rtl/mux_scan_seq_if.sv
// mux_scan_seq_if: command / status bundle between a scan controller and the
// mux_scan_seq sequencer, including the mux select and sampled mux output.
//   master : drives start/stop/cont/ch_mask/dwell and the mux output mux_y
//   slave  : the sequencer; drives sel/sel_valid/busy/frame_data/frame_valid
//            (and frame_chg when built with MUX_SCAN_CHG_EN)
// Optional macro: MUX_SCAN_CHG_EN adds frame_chg.
interface mux_scan_seq_if #(parameter int DWELL_W = 8);
  logic               start;
  logic               stop;
  logic               cont;
  logic [4:0]         ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic               mux_y;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               busy;
  logic [4:0]         frame_data;
  logic               frame_valid;
`ifdef MUX_SCAN_CHG_EN
  logic               frame_chg;
`endif

  modport master (
    output start, stop, cont, ch_mask, dwell, mux_y,
    input  sel, sel_valid, busy, frame_data, frame_valid
`ifdef MUX_SCAN_CHG_EN
    , input frame_chg
`endif
  );

  modport slave (
    input  start, stop, cont, ch_mask, dwell, mux_y,
    output sel, sel_valid, busy, frame_data, frame_valid
`ifdef MUX_SCAN_CHG_EN
    , output frame_chg
`endif
  );
endinterface

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: steps the select of a 5:1 single-bit mux through the enabled
// channels in ascending order, holds each for dwell+1 cycles, samples mux_y
// on the last cycle of each hold and emits the assembled 5-bit frame with a
// one-cycle frame_valid pulse (single-shot or continuous).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_scan_seq_if.slave (start/stop/cont/ch_mask/dwell/mux_y in,
//          sel/sel_valid/busy/frame_data/frame_valid[/frame_chg] out)
// Optional macro: MUX_SCAN_CHG_EN adds frame_chg, which pulses with
// frame_valid when the new frame differs from the previous completed one.
module mux_scan_seq #(
  parameter int DWELL_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  mux_scan_seq_if.slave  bus
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [4:0]         mask_q, mask_d;
  logic               cont_q, cont_d;
  logic [4:0]         shadow_q, shadow_d;
  logic [4:0]         frame_q, frame_d;
  logic               fvld_q, fvld_d;
  logic [4:0]         merged;
  logic [2:0]         nxt;
`ifdef MUX_SCAN_CHG_EN
  logic [4:0]         prev_q, prev_d;
  logic               chg_q, chg_d;
`endif

  // Lowest set bit of the mask (0 for an empty mask, never used that way).
  function automatic logic [2:0] lo_ch(input logic [4:0] m);
    lo_ch = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (m[i]) lo_ch = 3'(i);
  endfunction

  // Next enabled channel above cur; returns cur when cur is the highest.
  function automatic logic [2:0] nxt_ch(input logic [4:0] m, input logic [2:0] cur);
    nxt_ch = cur;
    for (int i = 4; i >= 0; i--)
      if (m[i] && (3'(i) > cur)) nxt_ch = 3'(i);
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    mask_d   = mask_q;
    cont_d   = cont_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fvld_d   = 1'b0;
`ifdef MUX_SCAN_CHG_EN
    prev_d   = prev_q;
    chg_d    = 1'b0;
`endif
    // sel_q is always 0..4, so the shift lands inside the 5-bit word.
    merged   = shadow_q | (5'(bus.mux_y) << sel_q);
    nxt      = nxt_ch(mask_q, sel_q);

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.ch_mask != 5'd0)) begin
          state_d  = SCAN;
          mask_d   = bus.ch_mask;
          dwell_d  = bus.dwell;
          cont_d   = bus.cont;
          shadow_d = 5'd0;
          cnt_d    = '0;
          sel_d    = lo_ch(bus.ch_mask);
        end
      end
      SCAN: begin
        if (bus.stop) begin
          // Partial frame dropped; frame_q is left untouched.
          state_d  = IDLE;
          sel_d    = 3'd0;
          cnt_d    = '0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (nxt != sel_q) begin
            sel_d    = nxt;
            shadow_d = merged;
          end else begin
            frame_d = merged;
            fvld_d  = 1'b1;
`ifdef MUX_SCAN_CHG_EN
            chg_d   = (merged != prev_q);
            prev_d  = merged;
`endif
            shadow_d = 5'd0;
            if (cont_q) begin
              sel_d   = lo_ch(mask_q);
            end else begin
              state_d = IDLE;
              sel_d   = 3'd0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 3'd0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      mask_q   <= 5'd0;
      cont_q   <= 1'b0;
      shadow_q <= 5'd0;
      frame_q  <= 5'd0;
      fvld_q   <= 1'b0;
`ifdef MUX_SCAN_CHG_EN
      prev_q   <= 5'd0;
      chg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fvld_q   <= fvld_d;
`ifdef MUX_SCAN_CHG_EN
      prev_q   <= prev_d;
      chg_q    <= chg_d;
`endif
    end
  end

  assign bus.sel         = sel_q;
  assign bus.sel_valid   = (state_q == SCAN);
  assign bus.busy        = (state_q == SCAN);
  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = fvld_q;
`ifdef MUX_SCAN_CHG_EN
  assign bus.frame_chg   = chg_q;
`endif

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Upstream sequencer for the team's 5:1 single-bit mux.
- Drives the mux's 3-bit select through enabled channels 0..4 in ascending order, holding each channel for a programmable dwell time.
- Samples the mux output at the end of each dwell and assembles the samples into a 5-bit frame word.
- Presents each completed frame with a one-cycle valid pulse, in single-shot or continuous mode.

Parameters:
- DWELL_W, 8, width of the dwell-count input. Hold time per channel = dwell+1 cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin scanning; ignored while busy
- stop  input  1  abort scanning; wins over start in the same cycle
- cont  input  1  1 = continuous frames, 0 = single frame; latched at start
- ch_mask  input  5  channel enable mask, bit i = channel i; latched at start
- dwell  input  DWELL_W  hold cycles minus one per channel; latched at start
- mux_y  input  1  output of the 5:1 mux
- sel  output  3  select to the mux; only values 0..4 are ever driven
- sel_valid  output  1  high while sel addresses a channel being scanned
- busy  output  1  high from the cycle after an accepted start until return to IDLE
- frame_data  output  5  last completed frame; bit i = sample of channel i, 0 if masked
- frame_valid  output  1  one-cycle pulse; frame_data updated in the same cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; sel=0, sel_valid=0, busy=0, frame_data=0, frame_valid=0. All internal counters, shadow register and latched config are cleared.
- Reset mid-scan: same reset values immediately; no frame_valid is produced.
- FSM states: IDLE, SCAN.
- IDLE:
  - Start is accepted when start=1, stop=0 and ch_mask!=0.
  - On acceptance: latch cont, ch_mask and dwell; clear the shadow register and dwell counter; sel = lowest enabled channel; sel_valid=1, busy=1; go to SCAN.
  - start with ch_mask==0 is ignored; stays IDLE with no pulses.
- SCAN:
  - Dwell counter counts 0..dwell_l; the edge at count==dwell_l is the sample edge.
  - At the sample edge, shadow[sel] <= mux_y.
  - If sel is not the highest enabled channel: sel <= next higher enabled channel (masked channels are skipped in zero cycles); counter <= 0.
  - If sel is the highest enabled channel: frame_data <= shadow with this edge's sample merged in; frame_valid <= 1 for one cycle.
    - cont_l=1: shadow cleared, sel <= lowest enabled channel, counter <= 0, stay in SCAN with no gap cycle.
    - cont_l=0: go to IDLE; sel=0, sel_valid=0, busy=0.
- Latency: with all 5 channels enabled, frame_valid rises (5 × (dwell+1)) edges after the start-accept edge.
- stop in SCAN: next edge goes to IDLE; sel=0, sel_valid=0, busy=0. The partial frame is discarded and frame_data keeps its previous value. stop coinciding with a last-sample edge also discards that frame (no frame_valid).
- start while busy: ignored. Config inputs changing mid-scan have no effect until the next accepted start.
- sel never takes values 5..7 in any state.

Optional Feature:
- Macro: MUX_SCAN_CHG_EN.
- Defined:
  - Adds output frame_chg (1 bit) and an internal previous-frame register, reset to 0.
  - frame_chg pulses together with frame_valid when the new frame_data differs from the previous completed frame.
  - The previous-frame register updates on every frame_valid.
  - The first frame after reset compares against 0.
- Undefined: no frame_chg port and no extra registers; behaviour otherwise identical.

Test Plan:
- ch_mask=5'h1F, dwell=0, cont=0, mux_y driven from d[4:0]=5'b10110 via a bench 5:1 model; start at edge E0 → sel=0,1,2,3,4 on consecutive cycles, frame_valid single pulse after E5, frame_data=5'b10110, then busy=0 and sel=0.
- ch_mask=5'b10100, dwell=2, constant mux_y=1 → sel=2 for 3 cycles then 4 for 3 cycles, frame_valid after edge 6, frame_data=5'b10100.
- cont=1, ch_mask=5'h1F, dwell=1, bench flips d each frame → frame_valid every 10 cycles with no gap, frame_data tracks d; MUX_SCAN_CHG_EN build: frame_chg=1 on each differing frame, 0 on a repeated frame.
- stop asserted mid-frame (3rd channel) → IDLE next edge, no frame_valid, frame_data unchanged, sel=0; start and stop in the same cycle → remains IDLE.
- start with ch_mask=0 → no busy, no pulses; start pulsed again while busy → no restart, frame timing unchanged.
- rst_n asserted asynchronously mid-dwell → all outputs go to their reset values immediately; after release, a fresh start behaves as in test 1.
